// File: rtl/axi_wr_arbiter_if.sv
// Bundled requester-side and master-side AXI write channels for the write arbiter.
// slave: the arbiter's view; master: the environment (requesters plus downstream slave).
interface axi_wr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
);
    logic [NREQ-1:0]        s_awvalid;
    logic [NREQ-1:0]        s_awready;
    logic [NREQ*AW-1:0]     s_awaddr;
    logic [NREQ*8-1:0]      s_awlen;
    logic [NREQ*3-1:0]      s_awsize;
    logic [NREQ*2-1:0]      s_awburst;
    logic [NREQ*DW-1:0]     s_wdata;
    logic [NREQ*DW/8-1:0]   s_wstrb;
    logic [NREQ-1:0]        s_wlast;
    logic [NREQ-1:0]        s_wvalid;
    logic [NREQ-1:0]        s_wready;
    logic [1:0]             s_bresp;
    logic [NREQ-1:0]        s_bvalid;
    logic [NREQ-1:0]        s_bready;

    logic [AW-1:0]          m_awaddr;
    logic [7:0]             m_awlen;
    logic [2:0]             m_awsize;
    logic [1:0]             m_awburst;
    logic                   m_awvalid;
    logic                   m_awready;
    logic [DW-1:0]          m_wdata;
    logic [DW/8-1:0]        m_wstrb;
    logic                   m_wlast;
    logic                   m_wvalid;
    logic                   m_wready;
    logic [1:0]             m_bresp;
    logic                   m_bvalid;
    logic                   m_bready;
    logic                   wlast_err;

    modport slave (
        input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready, wlast_err,
        input  m_awready, m_wready, m_bresp, m_bvalid
    );

    modport master (
        output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
        output s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready, wlast_err,
        output m_awready, m_wready, m_bresp, m_bvalid
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: NREQ requesters share one AW/W/B master port,
// one outstanding write at a time, W and B locked to the AW winner until its B handshake.
module axi_wr_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic             axi_aclk,
    input  logic             rst,
    axi_wr_arbiter_if.slave  bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state;
    logic [GW-1:0]   rr_ptr, grant, win_idx;
    logic            win_vld;
    logic [7:0]      len, beat_cnt;
    logic            beat;

    // Unpacked per-requester views keep every mux a plain array index.
    logic [AW-1:0]   awaddr_a  [NREQ];
    logic [7:0]      awlen_a   [NREQ];
    logic [2:0]      awsize_a  [NREQ];
    logic [1:0]      awburst_a [NREQ];
    logic [DW-1:0]   wdata_a   [NREQ];
    logic [SW-1:0]   wstrb_a   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign awaddr_a[i]  = bus.s_awaddr[i*AW +: AW];
        assign awlen_a[i]   = bus.s_awlen[i*8 +: 8];
        assign awsize_a[i]  = bus.s_awsize[i*3 +: 3];
        assign awburst_a[i] = bus.s_awburst[i*2 +: 2];
        assign wdata_a[i]   = bus.s_wdata[i*DW +: DW];
        assign wstrb_a[i]   = bus.s_wstrb[i*SW +: SW];
    end

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        logic [GW-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = GW'((int'(rr_ptr) + k) % NREQ);
            if (!win_vld && bus.s_awvalid[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        bus.s_awready = '0;
        if (state == IDLE && win_vld && !rst)
            bus.s_awready[win_idx] = 1'b1;
    end

    always_comb begin
        bus.m_wdata  = '0;
        bus.m_wstrb  = '0;
        bus.m_wvalid = 1'b0;
        bus.s_wready = '0;
        if (state == DATA) begin
            bus.m_wdata          = wdata_a[grant];
            bus.m_wstrb          = wstrb_a[grant];
            bus.m_wvalid         = bus.s_wvalid[grant];
            bus.s_wready[grant]  = bus.m_wready;
        end
    end

    assign bus.m_wlast = (state == DATA) && (beat_cnt == len);
    assign beat        = bus.m_wvalid && bus.m_wready;

    always_comb begin
        bus.s_bvalid = '0;
        bus.s_bresp  = '0;
        bus.m_bready = 1'b0;
        if (state == RESP) begin
            bus.s_bvalid[grant] = bus.m_bvalid;
            bus.s_bresp         = bus.m_bresp;
            bus.m_bready        = bus.s_bready[grant];
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant         <= '0;
            len           <= '0;
            beat_cnt      <= '0;
            bus.m_awaddr  <= '0;
            bus.m_awlen   <= '0;
            bus.m_awsize  <= '0;
            bus.m_awburst <= '0;
            bus.m_awvalid <= 1'b0;
            bus.wlast_err <= 1'b0;
        end else begin
            bus.wlast_err <= 1'b0;
            case (state)
                IDLE: if (win_vld) begin
                    grant         <= win_idx;
                    len           <= awlen_a[win_idx];
                    bus.m_awaddr  <= awaddr_a[win_idx];
                    bus.m_awlen   <= awlen_a[win_idx];
                    bus.m_awsize  <= awsize_a[win_idx];
                    bus.m_awburst <= awburst_a[win_idx];
                    bus.m_awvalid <= 1'b1;
                    state         <= ADDR;
                end
                ADDR: if (bus.m_awready) begin
                    bus.m_awvalid <= 1'b0;
                    beat_cnt      <= '0;
                    state         <= DATA;
                end
                // The requester's own last flag is only audited; the beat counter decides.
                DATA: if (beat) begin
                    beat_cnt      <= beat_cnt + 8'd1;
                    bus.wlast_err <= (bus.s_wlast[grant] != bus.m_wlast);
                    if (bus.m_wlast)
                        state <= RESP;
                end
                RESP: if (bus.m_bvalid && bus.m_bready) begin
                    rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + GW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: directed writes push expected AW/W/B/error
// records; one negedge monitor pops and compares whenever the DUT shows a handshake.
module tb_axi_wr_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;
    localparam int IW   = $clog2(NREQ);
    localparam int LIM  = 3000;

    logic axi_aclk = 1'b0;
    logic rst      = 1'b1;
    always #5 axi_aclk = ~axi_aclk;

    axi_wr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
    axi_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .axi_aclk (axi_aclk),
        .rst      (rst),
        .bus      (bus)
    );

    logic          r_awvalid [NREQ];
    logic [AW-1:0] r_awaddr  [NREQ];
    logic [7:0]    r_awlen   [NREQ];
    logic [2:0]    r_awsize  [NREQ];
    logic [1:0]    r_awburst [NREQ];
    logic [DW-1:0] r_wdata   [NREQ];
    logic [SW-1:0] r_wstrb   [NREQ];
    logic          r_wlast   [NREQ];
    logic          r_wvalid  [NREQ];
    logic          r_bready  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign bus.s_awvalid[i]            = r_awvalid[i];
        assign bus.s_awaddr[i*AW +: AW]    = r_awaddr[i];
        assign bus.s_awlen[i*8 +: 8]       = r_awlen[i];
        assign bus.s_awsize[i*3 +: 3]      = r_awsize[i];
        assign bus.s_awburst[i*2 +: 2]     = r_awburst[i];
        assign bus.s_wdata[i*DW +: DW]     = r_wdata[i];
        assign bus.s_wstrb[i*SW +: SW]     = r_wstrb[i];
        assign bus.s_wlast[i]              = r_wlast[i];
        assign bus.s_wvalid[i]             = r_wvalid[i];
        assign bus.s_bready[i]             = r_bready[i];
    end

    logic       tb_awready = 1'b0;
    logic       tb_wready  = 1'b0;
    logic       tb_bvalid  = 1'b0;
    logic [1:0] tb_bresp   = 2'b00;
    logic       stall_en   = 1'b0;
    assign bus.m_awready = tb_awready;
    assign bus.m_wready  = tb_wready;
    assign bus.m_bvalid  = tb_bvalid;
    assign bus.m_bresp   = tb_bresp;

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } aw_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } w_t;
    typedef struct { int id; logic [1:0] resp; } b_t;
    aw_t aw_q[$];
    w_t  w_q[$];
    b_t  b_q[$];
    int  err_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        return {a, 32'(b)};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int b);
        logic [SW-1:0] s;
        s = '1;
        return s >> (b % SW);
    endfunction

    // Hand-ordered expectations: callers push in the grant order they predict.
    task automatic expect_write(input int id, input logic [AW-1:0] addr, input int len, input int bad);
        aw_t a;
        w_t  w;
        b_t  b;
        a.addr = addr; a.len = 8'(len); a.size = 3'(id + 2); a.burst = 2'(id + 1);
        aw_q.push_back(a);
        for (int k = 0; k <= len; k++) begin
            w.data = beat_data(addr, k); w.strb = beat_strb(k); w.last = (k == len);
            w_q.push_back(w);
        end
        b.id = id; b.resp = addr[5:4];
        b_q.push_back(b);
        if (bad >= 0) err_q.push_back(id);
    endtask

    task automatic drive_write(input int id, input logic [AW-1:0] addr, input int len, input int bad);
        logic [IW-1:0] ix;
        int t;
        ix = IW'(id);
        r_awvalid[ix] = 1'b1; r_awaddr[ix] = addr; r_awlen[ix] = 8'(len);
        r_awsize[ix] = 3'(id + 2); r_awburst[ix] = 2'(id + 1);
        t = 0;
        do begin @(negedge axi_aclk); t++; end while (!bus.s_awready[ix] && t < LIM);
        check("aw_wait_timeout", 128'(t >= LIM), 128'(0));
        @(posedge axi_aclk); #1;
        r_awvalid[ix] = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (stall_en && $urandom_range(0, 2) == 0) begin
                r_wvalid[ix] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge axi_aclk);
                #1;
            end
            r_wvalid[ix] = 1'b1; r_wdata[ix] = beat_data(addr, k);
            r_wstrb[ix] = beat_strb(k); r_wlast[ix] = (k == len) || (k == bad);
            t = 0;
            do begin @(negedge axi_aclk); t++; end while (!bus.s_wready[ix] && t < LIM);
            check("w_wait_timeout", 128'(t >= LIM), 128'(0));
            @(posedge axi_aclk); #1;
        end
        r_wvalid[ix] = 1'b0; r_wlast[ix] = 1'b0;
        r_bready[ix] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        t = 0;
        forever begin
            @(negedge axi_aclk); t++;
            if ((bus.s_bvalid[ix] && r_bready[ix]) || t >= LIM) break;
            @(posedge axi_aclk); #1;
            r_bready[ix] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("b_wait_timeout", 128'(t >= LIM), 128'(0));
        @(posedge axi_aclk); #1;
        r_bready[ix] = 1'b0;
    endtask

    // Downstream ready generators: a stall of 0-5 cycles, then one ready cycle.
    initial begin
        int ca, cw;
        ca = 0; cw = 0;
        forever begin
            @(posedge axi_aclk); #1;
            if (ca == 0) ca = stall_en ? $urandom_range(0, 5) : 0; else ca--;
            if (cw == 0) cw = stall_en ? $urandom_range(0, 5) : 0; else cw--;
            tb_awready = (ca == 0);
            tb_wready  = (cw == 0);
        end
    end

    // Downstream B responder: answers each last beat with resp = awaddr[5:4].
    initial begin
        int t;
        forever begin
            @(negedge axi_aclk);
            if (!rst && bus.m_wvalid && bus.m_wready && bus.m_wlast) begin
                tb_bresp = bus.m_awaddr[5:4];
                @(posedge axi_aclk); #1;
                if (stall_en) begin
                    repeat ($urandom_range(0, 3)) @(posedge axi_aclk);
                    #1;
                end
                tb_bvalid = 1'b1;
                t = 0;
                do begin @(negedge axi_aclk); t++; end while (!bus.m_bready && t < LIM);
                @(posedge axi_aclk); #1;
                tb_bvalid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic          aw_hold, b_prev;
        logic [44:0]   aw_held;
        logic [NREQ-1:0] one;
        aw_t a; w_t w; b_t b;
        aw_hold = 1'b0; b_prev = 1'b0; aw_held = '0;
        forever begin
            @(negedge axi_aclk);
            if (rst) begin
                aw_hold = 1'b0; b_prev = 1'b0;
            end else begin
                if (aw_hold)
                    check("aw_stable", {bus.m_awvalid, bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst},
                          {1'b1, aw_held});
                if (b_prev && (bus.s_awvalid != '0))
                    check("turnaround_grant", 128'(bus.s_awready != '0), 128'(1));
                aw_hold = bus.m_awvalid && !bus.m_awready;
                aw_held = {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst};
                b_prev  = 1'b0;
                if (bus.m_awvalid && bus.m_awready) begin
                    check("aw_expected", 128'(aw_q.size() != 0), 128'(1));
                    if (aw_q.size() != 0) begin
                        a = aw_q.pop_front();
                        check("aw_payload", {bus.m_awaddr, bus.m_awlen, bus.m_awsize, bus.m_awburst},
                              {a.addr, a.len, a.size, a.burst});
                    end
                end
                if (bus.m_wvalid && bus.m_wready) begin
                    check("w_expected", 128'(w_q.size() != 0), 128'(1));
                    if (w_q.size() != 0) begin
                        w = w_q.pop_front();
                        check("w_beat", {bus.m_wdata, bus.m_wstrb, bus.m_wlast}, {w.data, w.strb, w.last});
                    end
                end
                if ((bus.s_bvalid & bus.s_bready) != '0) begin
                    b_prev = 1'b1;
                    check("b_expected", 128'(b_q.size() != 0), 128'(1));
                    if (b_q.size() != 0) begin
                        b = b_q.pop_front();
                        one = '0; one[IW'(b.id)] = 1'b1;
                        check("b_route", {bus.s_bvalid, bus.s_bresp}, {one, b.resp});
                    end
                end
                if (bus.wlast_err) begin
                    check("wlast_err_expected", 128'(err_q.size() != 0), 128'(1));
                    if (err_q.size() != 0) void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_idle_outputs(input string name);
        check(name, {bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready, bus.wlast_err,
                     bus.s_awready, bus.s_wready, bus.s_bvalid, bus.m_awaddr, bus.m_awlen}, 128'(0));
    endtask

    initial begin
        int t;
        for (int i = 0; i < NREQ; i++) begin
            r_awvalid[i] = 0; r_awaddr[i] = '0; r_awlen[i] = '0; r_awsize[i] = '0; r_awburst[i] = '0;
            r_wdata[i] = '0; r_wstrb[i] = '0; r_wlast[i] = 0; r_wvalid[i] = 0; r_bready[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge axi_aclk);
        #1;
        check_idle_outputs("reset_state");
        rst = 1'b0;

        // Single requester, 4 beats; AW latency is one cycle.
        expect_write(0, 32'h100, 3, -1);
        fork
            drive_write(0, 32'h100, 3, -1);
            begin
                @(negedge axi_aclk);
                check("aw_lat_t", {bus.m_awvalid, bus.s_awready}, {1'b0, 2'b01});
                @(negedge axi_aclk);
                check("aw_lat_t1", {bus.m_awvalid, bus.m_awaddr}, {1'b1, 32'h100});
            end
        join
        repeat (2) @(posedge axi_aclk);
        #1;

        // Requester 1 flags last on beat 2 of 4: one error pulse, m_wlast still on beat 4.
        expect_write(1, 32'h1010, 3, 1);
        drive_write(1, 32'h1010, 3, 1);

        // Both request continuously from rr_ptr=0: 0,1,0,1.
        expect_write(0, 32'h2020, 1, -1);
        expect_write(1, 32'h3030, 2, -1);
        expect_write(0, 32'h2120, 0, -1);
        expect_write(1, 32'h3130, 1, -1);
        fork
            begin drive_write(0, 32'h2020, 1, -1); drive_write(0, 32'h2120, 0, -1); end
            begin drive_write(1, 32'h3030, 2, -1); drive_write(1, 32'h3130, 1, -1); end
        join

        // Burst length extremes.
        expect_write(0, 32'h4040, 0, -1);
        drive_write(0, 32'h4040, 0, -1);
        expect_write(0, 32'h5050, 255, -1);
        drive_write(0, 32'h5050, 255, -1);

        // Random stalls on every channel; rr_ptr=1 so requester 1 leads.
        stall_en = 1'b1;
        expect_write(1, 32'h6060, 3, -1);
        expect_write(0, 32'h7070, 2, -1);
        expect_write(1, 32'h6160, 1, -1);
        expect_write(0, 32'h7170, 0, -1);
        fork
            begin drive_write(1, 32'h6060, 3, -1); drive_write(1, 32'h6160, 1, -1); end
            begin drive_write(0, 32'h7070, 2, -1); drive_write(0, 32'h7170, 0, -1); end
        join
        stall_en = 1'b0;
        repeat (8) @(posedge axi_aclk);
        #1;

        // Reset during beat 2 of 4: only the AW and beat 1 complete.
        begin
            aw_t a; w_t w;
            a.addr = 32'h8080; a.len = 8'd3; a.size = 3'd2; a.burst = 2'd1;
            aw_q.push_back(a);
            w.data = beat_data(32'h8080, 0); w.strb = beat_strb(0); w.last = 1'b0;
            w_q.push_back(w);
        end
        r_awvalid[0] = 1'b1; r_awaddr[0] = 32'h8080; r_awlen[0] = 8'd3;
        r_awsize[0] = 3'd2; r_awburst[0] = 2'd1;
        t = 0;
        do begin @(negedge axi_aclk); t++; end while (!bus.s_awready[0] && t < LIM);
        check("rst_aw_timeout", 128'(t >= LIM), 128'(0));
        @(posedge axi_aclk); #1;
        r_awvalid[0] = 1'b0;
        r_wvalid[0] = 1'b1; r_wdata[0] = beat_data(32'h8080, 0); r_wstrb[0] = beat_strb(0);
        t = 0;
        do begin @(negedge axi_aclk); t++; end while (!bus.s_wready[0] && t < LIM);
        check("rst_w_timeout", 128'(t >= LIM), 128'(0));
        @(posedge axi_aclk); #1;
        r_wdata[0] = beat_data(32'h8080, 1); r_wstrb[0] = beat_strb(1);
        rst = 1'b1;
        @(posedge axi_aclk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            r_wvalid[i] = 0; r_wdata[i] = '0; r_wstrb[i] = '0; r_awaddr[i] = '0; r_awlen[i] = '0;
        end
        @(negedge axi_aclk);
        check_idle_outputs("midburst_reset");

        // rr_ptr was 1 before reset; back at 0, requester 0 wins.
        expect_write(0, 32'h9090, 1, -1);
        expect_write(1, 32'hA0A0, 0, -1);
        @(posedge axi_aclk); #1;
        fork
            drive_write(0, 32'h9090, 1, -1);
            drive_write(1, 32'hA0A0, 0, -1);
        join

        repeat (5) @(posedge axi_aclk);
        #1;
        check("aw_q_drained", 128'(aw_q.size()), 128'(0));
        check("w_q_drained", 128'(w_q.size()), 128'(0));
        check("b_q_drained", 128'(b_q.size()), 128'(0));
        check("err_q_drained", 128'(err_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
